// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch PC register with 2-bit counter branch prediction and execute-stage redirect
module branch_pc_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BHT_ENTRIES = 16,
    parameter int              PC_STEP     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            if_is_branch,
    input  logic [XLEN-1:0] if_br_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [1:0]      ex_kind,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            redirect,
    output logic [31:0]     mispredict_cnt
);
    localparam int IDXW = $clog2(BHT_ENTRIES);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
    logic [1:0]      bht [BHT_ENTRIES];
    logic            is_br, is_jmp;
    logic [IDXW-1:0] ex_idx;
    logic [1:0]      ctr, ctr_next;
    logic [XLEN-1:0] redir_tgt, next_pc;
    assign ex_idx = ex_pc[IDXW+1:2];
    assign is_br  = ex_valid & (ex_kind == 2'b01);
    assign is_jmp = ex_valid & (ex_kind == 2'b10);
    assign ctr    = bht[ex_idx];
    always_comb begin
        pred_taken = if_is_branch & bht[pc[IDXW+1:2]][1];
        redirect   = is_jmp | (is_br & (ex_taken != ex_pred_taken));
        redir_tgt  = (is_jmp | ex_taken) ? ex_target : ex_pc + STEP;
        next_pc    = redirect ? redir_tgt : stall ? pc : pred_taken ? if_br_target : pc + STEP;
        ctr_next   = ex_taken ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                              : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            mispredict_cnt <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else begin
            pc             <= next_pc;
            mispredict_cnt <= mispredict_cnt + {31'b0, redirect};
            if (is_br) bht[ex_idx] <= ctr_next;
        end
    end
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed checks of prediction, training, redirect, stall, aliasing and reset
module tb_branch_pc_unit;
    logic        clk = 0, rst, stall, if_is_branch, ex_valid, ex_taken, ex_pred_taken;
    logic [31:0] if_br_target, ex_pc, ex_target, pc, mispredict_cnt;
    logic [1:0]  ex_kind;
    logic        pred_taken, redirect;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_cnt = 0;

    branch_pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .if_is_branch(if_is_branch),
        .if_br_target(if_br_target), .pc(pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .redirect(redirect),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic jmp(input logic [31:0] tgt);
        ex_valid = 1; ex_kind = 2'b10; ex_target = tgt;
        step();
        ex_valid = 0;
        exp_cnt++;
    endtask

    // one conditional-branch resolution; checks redirect and, if redirecting, the new pc
    task automatic res(input logic [31:0] a, input logic tk, input logic pr, input logic exp_r);
        ex_valid = 1; ex_kind = 2'b01; ex_pc = a; ex_taken = tk; ex_pred_taken = pr;
        ex_target = 32'h40;
        #1 chk("redirect", {31'b0, redirect}, {31'b0, exp_r});
        step();
        ex_valid = 0;
        if (exp_r) begin
            exp_cnt++;
            chk("redir_pc", pc, tk ? 32'h40 : a + 32'd4);
        end
        chk("cnt", mispredict_cnt, exp_cnt);
    endtask

    task automatic fetch_pred(input logic [31:0] a, input logic exp_p);
        jmp(a);
        chk("fetch_pc", pc, a);
        if_is_branch = 1; if_br_target = 32'h40;
        #1 chk("pred", {31'b0, pred_taken}, {31'b0, exp_p});
        step();
        chk("pred_pc", pc, exp_p ? 32'h40 : a + 32'd4);
        if_is_branch = 0;
    endtask

    initial begin
        rst = 1; stall = 0; if_is_branch = 0; if_br_target = 0; ex_valid = 0;
        ex_kind = 0; ex_pc = 0; ex_taken = 0; ex_target = 0; ex_pred_taken = 0;
        // T1 reset and sequential fetch
        repeat (2) step();
        rst = 0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_cnt", mispredict_cnt, 32'h0);
        step(); chk("seq4", pc, 32'h4);
        step(); chk("seq8", pc, 32'h8);
        step(); chk("seq12", pc, 32'hC);
        step(); chk("seq16", pc, 32'h10);
        // T2 cold branch predicts not taken, later resolves taken
        if_is_branch = 1; if_br_target = 32'h40;
        #1 chk("cold_pred", {31'b0, pred_taken}, 32'h0);
        step(); chk("cold_pc", pc, 32'h14);
        if_is_branch = 0;
        res(32'h10, 1, 0, 1);              // idx4 01->10
        // T3 training
        res(32'h10, 1, 1, 0);              // 10->11
        fetch_pred(32'h10, 1);
        res(32'h10, 0, 1, 1);              // 11->10
        fetch_pred(32'h10, 1);
        // T4 saturation at 00 on idx 3
        res(32'hC, 0, 0, 0);
        res(32'hC, 0, 0, 0);
        fetch_pred(32'hC, 0);
        repeat (3) res(32'hC, 0, 0, 0);
        res(32'hC, 1, 0, 1);               // 00->01
        fetch_pred(32'hC, 0);
        res(32'hC, 1, 0, 1);               // 01->10
        fetch_pred(32'hC, 1);
        // T5 jump wins over stall; jump leaves BHT alone; kind 11 is inert
        stall = 1; ex_pc = 32'hC; ex_taken = 0;
        ex_valid = 1; ex_kind = 2'b10; ex_target = 32'h200;
        #1 chk("jmp_redir", {31'b0, redirect}, 32'h1);
        step(); exp_cnt++;
        chk("jmp_pc", pc, 32'h200);
        ex_kind = 2'b11;
        #1 chk("rsv_redir", {31'b0, redirect}, 32'h0);
        ex_valid = 0; if_is_branch = 1; if_br_target = 32'h40;
        step(); chk("stall_pc", pc, 32'h200);
        chk("stall_cnt", mispredict_cnt, exp_cnt);
        stall = 0; if_is_branch = 0;
        fetch_pred(32'hC, 1);
        // T6 aliasing: 0x10 and 0x50 share idx4 (currently 10)
        res(32'h50, 1, 0, 1);              // 10->11
        res(32'h10, 1, 1, 0);              // stays 11
        res(32'h50, 0, 1, 1);              // 11->10
        res(32'h10, 0, 1, 1);              // 10->01
        fetch_pred(32'h50, 0);
        // PC wrap is silent
        jmp(32'hFFFF_FFFC);
        step(); chk("wrap_pc", pc, 32'h0);
        // reset wins over a same-cycle redirect
        ex_valid = 1; ex_kind = 2'b10; ex_target = 32'h300; rst = 1;
        step();
        ex_valid = 0; rst = 0; exp_cnt = 0;
        chk("rstr_pc", pc, 32'h0);
        chk("rstr_cnt", mispredict_cnt, 32'h0);
        // same-cycle read/update of one entry uses the old counter (01 after reset)
        jmp(32'h10);
        if_is_branch = 1; if_br_target = 32'h40;
        ex_valid = 1; ex_kind = 2'b01; ex_pc = 32'h10; ex_taken = 1; ex_pred_taken = 1;
        #1 chk("rw_pred", {31'b0, pred_taken}, 32'h0);
        step(); chk("rw_pc", pc, 32'h14);
        ex_valid = 0; if_is_branch = 0;
        fetch_pred(32'h10, 1);
        chk("end_cnt", mispredict_cnt, exp_cnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
